// File: rtl/scan_crypto_sequencer.sv
// Sequencer for one secure scan session: key expansion, SIPO load, decrypt wait, TDR shift/update/capture, flush.
// Optional SEQ_CYCLE_CNT_EN adds the cyc_cnt busy-cycle counter output.
module scan_crypto_sequencer #(
    parameter int unsigned BLOCK_BITS     = 128,
    parameter int unsigned CHAIN_LEN      = 128,
    parameter int unsigned KEY_EXP_CYCLES = 11,
    parameter int unsigned DEC_LATENCY    = 23,
    parameter int unsigned BLK_W          = 8
) (
    input  logic             tck,
    input  logic             reset_n,
    input  logic             go,
    input  logic             rekey,
    input  logic [BLK_W-1:0] num_blocks,
    input  logic             abort,
    output logic             ka_rst_n,
    output logic             ka_start,
    output logic             crypto_en,
    output logic             sipo_load,
    output logic             shift_en,
    output logic             update_en,
    output logic             capture_en,
    output logic             busy,
    output logic             done,
    output logic             key_valid,
    output logic [BLK_W-1:0] blk_cnt,
`ifdef SEQ_CYCLE_CNT_EN
    output logic [31:0]      cyc_cnt,
`endif
    output logic [2:0]       state
);

    localparam int unsigned MAX_AB  = (BLOCK_BITS > CHAIN_LEN) ? BLOCK_BITS : CHAIN_LEN;
    localparam int unsigned MAX_CD  = (DEC_LATENCY > KEY_EXP_CYCLES) ? DEC_LATENCY : KEY_EXP_CYCLES;
    localparam int unsigned MAX_LEN = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned CMP_W   = BLK_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY   = 3'd1,
        S_LOAD  = 3'd2,
        S_DWAIT = 3'd3,
        S_SHIFT = 3'd4,
        S_UPD   = 3'd5,
        S_CAP   = 3'd6,
        S_FLUSH = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   nb_q, nb_d;
    logic [BLK_W-1:0]   blk_d;
    logic               kv_d, ka_rst_d, done_d;
    logic               phase_last;

    // Final phase-counter value for each state; single-cycle states end at 0.
    function automatic logic [CNT_W-1:0] last_of(input state_t s);
        case (s)
            S_KEY:   last_of = CNT_W'(KEY_EXP_CYCLES - 1);
            S_LOAD:  last_of = CNT_W'(BLOCK_BITS - 1);
            S_DWAIT: last_of = CNT_W'(DEC_LATENCY - 1);
            S_SHIFT: last_of = CNT_W'(CHAIN_LEN - 1);
            S_FLUSH: last_of = CNT_W'(CHAIN_LEN - 1);
            default: last_of = '0;
        endcase
    endfunction

    assign phase_last = (cnt_q == last_of(state_q));

    // Next state, phase counter and session bookkeeping.
    always_comb begin
        state_d  = state_q;
        nb_d     = nb_q;
        blk_d    = blk_cnt;
        kv_d     = key_valid;
        ka_rst_d = ka_rst_n;
        done_d   = 1'b0;
        cnt_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    nb_d  = num_blocks;
                    blk_d = '0;
                    if (rekey || !key_valid) begin
                        state_d = S_KEY;
                    end else if (num_blocks == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_KEY: begin
                if (phase_last) begin
                    kv_d    = 1'b1;
                    state_d = (nb_q == '0) ? S_IDLE : S_LOAD;
                end
            end
            S_LOAD:  if (phase_last) state_d = S_DWAIT;
            S_DWAIT: if (phase_last) state_d = S_SHIFT;
            S_SHIFT: if (phase_last) state_d = S_UPD;
            S_UPD:   state_d = S_CAP;
            S_CAP: begin
                blk_d = blk_cnt + BLK_W'(1);
                if ((CMP_W'(blk_cnt) + CMP_W'(1)) < CMP_W'(nb_q)) begin
                    state_d = S_LOAD;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (phase_last) state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && abort) begin
            state_d  = S_IDLE;
            ka_rst_d = 1'b0;
            blk_d    = blk_cnt;
            if (state_q == S_KEY) begin
                kv_d = 1'b0;
            end
        end

        if (state_d == S_KEY) begin
            ka_rst_d = 1'b1;
        end

        if (state_d != S_IDLE && state_d == state_q) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // done is registered, so it is raised for the cycle that will be the session's last.
        if ((state_d == S_FLUSH && cnt_d == last_of(S_FLUSH)) ||
            (state_d == S_KEY && cnt_d == last_of(S_KEY) && nb_d == '0)) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            nb_q       <= '0;
            blk_cnt    <= '0;
            key_valid  <= 1'b0;
            ka_rst_n   <= 1'b0;
            ka_start   <= 1'b0;
            crypto_en  <= 1'b0;
            sipo_load  <= 1'b0;
            shift_en   <= 1'b0;
            update_en  <= 1'b0;
            capture_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nb_q       <= nb_d;
            blk_cnt    <= blk_d;
            key_valid  <= kv_d;
            ka_rst_n   <= ka_rst_d;
            ka_start   <= (state_d == S_KEY);
            crypto_en  <= (state_d != S_IDLE);
            sipo_load  <= (state_d == S_LOAD);
            shift_en   <= (state_d == S_SHIFT) || (state_d == S_FLUSH);
            update_en  <= (state_d == S_UPD);
            capture_en <= (state_d == S_CAP);
            busy       <= (state_d != S_IDLE);
            done       <= done_d;
        end
    end

    assign state = state_q;

`ifdef SEQ_CYCLE_CNT_EN
    // Busy-cycle counter, restarted when a session is accepted.
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt <= '0;
        end else if (state_q == S_IDLE && go) begin
            cyc_cnt <= '0;
        end else if (busy) begin
            cyc_cnt <= cyc_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_scan_crypto_sequencer.sv
// Scoreboard bench for scan_crypto_sequencer: per-session expectations queued at go, checked at session end.
module tb_scan_crypto_sequencer;

    localparam int K = 11;
    localparam int B = 128;
    localparam int D = 23;
    localparam int C = 128;

    logic       tck = 1'b0;
    logic       reset_n;
    logic       go, rekey, abort;
    logic [7:0] num_blocks;
    logic       ka_rst_n, ka_start, crypto_en, sipo_load, shift_en, update_en, capture_en;
    logic       busy, done, key_valid;
    logic [7:0] blk_cnt;
    logic [2:0] state;
`ifdef SEQ_CYCLE_CNT_EN
    logic [31:0] cyc_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit kv_m     = 1'b0;
    bit ka_rst_m = 1'b0;

    typedef struct {
        int busy_n;
        int ka_n;
        int sipo_n;
        int shift_n;
        int upd_n;
        int cap_n;
        int done_n;
        int done_idx;
        int gap;
        int blk;
        int kv;
        int ka_rst;
        int first_state;
    } sess_t;

    sess_t sbq[$];

    always #5 tck = ~tck;

    scan_crypto_sequencer dut (
        .tck        (tck),
        .reset_n    (reset_n),
        .go         (go),
        .rekey      (rekey),
        .num_blocks (num_blocks),
        .abort      (abort),
        .ka_rst_n   (ka_rst_n),
        .ka_start   (ka_start),
        .crypto_en  (crypto_en),
        .sipo_load  (sipo_load),
        .shift_en   (shift_en),
        .update_en  (update_en),
        .capture_en (capture_en),
        .busy       (busy),
        .done       (done),
        .key_valid  (key_valid),
        .blk_cnt    (blk_cnt),
`ifdef SEQ_CYCLE_CNT_EN
        .cyc_cnt    (cyc_cnt),
`endif
        .state      (state)
    );

    task automatic chk(input string tag, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ka_rst_n"}, ka_rst_n, 0);
        chk({tag, "_enables"}, {ka_start, crypto_en, sipo_load, shift_en, update_en, capture_en}, 0);
        chk({tag, "_busy_done"}, {busy, done}, 0);
        chk({tag, "_key_valid"}, key_valid, 0);
        chk({tag, "_blk_cnt"}, blk_cnt, 0);
        chk({tag, "_state"}, state, 0);
    endtask

    // One session: expected profile is queued at go, measured profile compared when busy falls.
    task automatic session(input bit rk, input int nb, input int abort_at, input bit go_abort);
        sess_t e, a, x;
        bit    key, stop, aborted;
        int    len, c, last_sipo, mux;
        key = rk || !kv_m;
        len = (key ? K : 0) + nb * (B + D + C + 2) + ((nb > 0) ? C : 0);
        e.busy_n   = len;
        e.ka_n     = key ? K : 0;
        e.sipo_n   = nb * B;
        e.shift_n  = nb * C + ((nb > 0) ? C : 0);
        e.upd_n    = nb;
        e.cap_n    = nb;
        e.done_n   = 1;
        e.done_idx = (len > 0) ? len - 1 : 0;
        e.gap      = (nb > 0) ? D : -1;
        e.blk      = nb;
        if (key) begin
            kv_m     = 1'b1;
            ka_rst_m = 1'b1;
        end
        e.first_state = key ? 1 : ((nb > 0) ? 2 : 0);
        if (abort_at > 0) begin
            e.busy_n   = (key ? K : 0) + B + D + abort_at;
            e.sipo_n   = B;
            e.shift_n  = abort_at;
            e.upd_n    = 0;
            e.cap_n    = 0;
            e.done_n   = 0;
            e.done_idx = -1;
            e.blk      = 0;
            ka_rst_m   = 1'b0;
        end
        e.kv     = kv_m;
        e.ka_rst = ka_rst_m;
        sbq.push_back(e);

        @(negedge tck);
        go         = 1'b1;
        rekey      = rk;
        num_blocks = 8'(nb);
        abort      = go_abort;

        a = '{default: 0};
        a.done_idx = -1;
        a.gap      = -1;
        last_sipo  = -1;
        mux        = 0;
        c          = 0;
        stop       = 1'b0;
        aborted    = 1'b0;
        while (!stop) begin
            @(negedge tck);
            if (c == 0) begin
                a.first_state = int'(state);
                if (abort_at == 0) go = 1'b0;
                abort = 1'b0;
            end
            if (busy) a.busy_n++;
            if (ka_start) a.ka_n++;
            if (sipo_load) begin
                a.sipo_n++;
                last_sipo = c;
            end
            if (shift_en) begin
                if (a.shift_n == 0 && last_sipo >= 0) a.gap = c - last_sipo - 1;
                a.shift_n++;
            end
            if (update_en) a.upd_n++;
            if (capture_en) a.cap_n++;
            if (done) begin
                a.done_n++;
                a.done_idx = c;
            end
            if (int'(sipo_load) + int'(shift_en) + int'(update_en) + int'(capture_en) > 1) mux++;
            if (!busy) begin
                stop = 1'b1;
            end else if (abort_at > 0 && !aborted && a.shift_n == abort_at) begin
                abort   = 1'b1;
                go      = 1'b0;
                aborted = 1'b1;
            end
            c++;
            if (!stop && c > 3000) begin
                chk("session_timeout", c, 0);
                stop = 1'b1;
            end
        end
        abort    = 1'b0;
        go       = 1'b0;
        a.blk    = int'(blk_cnt);
        a.kv     = int'(key_valid);
        a.ka_rst = int'(ka_rst_n);
        chk("idle_enables", {ka_start, crypto_en, sipo_load, shift_en, update_en, capture_en}, 0);
        chk("mutex", mux, 0);
        @(negedge tck);
        chk("done_single", done, 0);
        chk("idle_state", state, 0);

        x = sbq.pop_front();
        chk("busy_cycles", a.busy_n, x.busy_n);
        chk("ka_start_cycles", a.ka_n, x.ka_n);
        chk("sipo_cycles", a.sipo_n, x.sipo_n);
        chk("shift_cycles", a.shift_n, x.shift_n);
        chk("update_cycles", a.upd_n, x.upd_n);
        chk("capture_cycles", a.cap_n, x.cap_n);
        chk("done_pulses", a.done_n, x.done_n);
        chk("done_index", a.done_idx, x.done_idx);
        chk("dwait_gap", a.gap, x.gap);
        chk("blk_cnt", a.blk, x.blk);
        chk("key_valid", a.kv, x.kv);
        chk("ka_rst_n", a.ka_rst, x.ka_rst);
        chk("first_state", a.first_state, x.first_state);
    endtask

    initial begin
        reset_n    = 1'b0;
        go         = 1'b0;
        rekey      = 1'b0;
        abort      = 1'b0;
        num_blocks = 8'd0;
        repeat (3) @(negedge tck);
        chk_all_zero("in_reset");
        reset_n = 1'b1;
        repeat (5) @(negedge tck);
        chk_all_zero("post_reset");

        // Rekey, single block: 420-cycle session.
        session(1'b1, 1, 0, 1'b0);
`ifdef SEQ_CYCLE_CNT_EN
        chk("cyc_cnt", cyc_cnt, 420);
`endif
        // Key reuse, three blocks.
        session(1'b0, 3, 0, 1'b0);
        // Zero blocks with and without key expansion.
        session(1'b1, 0, 0, 1'b0);
        session(1'b0, 0, 0, 1'b0);
        // Abort in the 50th SHIFT cycle with go held high while busy.
        session(1'b0, 1, 50, 1'b0);
        // go and abort together in IDLE: go is accepted.
        session(1'b0, 2, 0, 1'b1);

        // Asynchronous reset in the middle of a session.
        @(negedge tck);
        go         = 1'b1;
        rekey      = 1'b1;
        num_blocks = 8'd1;
        @(negedge tck);
        go = 1'b0;
        repeat (20) @(negedge tck);
        chk("pre_reset_busy", busy, 1);
        #2 reset_n = 1'b0;
        #1 chk_all_zero("async_reset");
        @(negedge tck);
        reset_n  = 1'b1;
        kv_m     = 1'b0;
        ka_rst_m = 1'b0;
        // Key lost by reset: rekey=0 must still expand the key.
        session(1'b0, 1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_crypto_sequencer.md
Name: scan_crypto_sequencer

Overview:
- Controller that sequences one secure IEEE 1838 scan session through the decrypt -> TDR scan chain -> encrypt datapath.
- Generates the key-expansion reset and start, the crypto enable, the SIPO load window, and shift/update/capture to the TDR, so that no bench or TAP logic has to hand-time them.
- Sits between the TAP/die-wrapper control logic and the decrypt-scan-encrypt datapath, all in the tck domain.

Parameters:
- BLOCK_BITS, 128, ciphertext bits serially loaded into the decrypt SIPO per block.
- CHAIN_LEN, 128, TDR scan-chain length; the shift_en cycles per shift burst.
- KEY_EXP_CYCLES, 11, cycles allowed for key expansion after ka_start.
- DEC_LATENCY, 23, cycles from the last SIPO bit to decrypted data available at the chain input.
- BLK_W, 8, width of the block counter and of num_blocks.

Ports:
- tck  in  1  scan clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset of the whole block.
- go  in  1  starts a session; sampled only in IDLE.
- rekey  in  1  sampled with go; 1 runs key expansion first.
- num_blocks  in  BLK_W  blocks to process in the session; sampled with go.
- abort  in  1  synchronous abort; highest priority in every non-IDLE state.
- ka_rst_n  out  1  active-low reset to the key-expansion unit.
- ka_start  out  1  key-expansion start.
- crypto_en  out  1  enable to the decrypt/encrypt cores.
- sipo_load  out  1  high while TDI ciphertext bits are clocked into the SIPO.
- shift_en  out  1  TDR shift.
- update_en  out  1  TDR update; exactly 1 cycle per block.
- capture_en  out  1  TDR capture; exactly 1 cycle per block.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse when a session ends normally.
- key_valid  out  1  expanded key available; set at the end of KEY, cleared by reset or abort during KEY.
- blk_cnt  out  BLK_W  blocks fully completed (update and capture done) in the current session.
- state  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, KEY=1, LOAD=2, DWAIT=3, SHIFT=4, UPD=5, CAP=6, FLUSH=7. DONE is not a separate state: done pulses in the last FLUSH cycle (or the last KEY cycle when num_blocks=0).
- Reset values:
  - All outputs 0, including ka_rst_n=0, key_valid=0 and blk_cnt=0.
  - state=IDLE; internal phase counter 0.
- IDLE:
  - All enables low; ka_rst_n keeps its last value.
  - go=1 with rekey=1, or with key_valid=0, moves to KEY.
  - go=1 with rekey=0 and key_valid=1 moves to LOAD; if num_blocks=0 instead, done pulses in the same cycle and the block stays in IDLE.
  - go is ignored while busy.
- KEY, KEY_EXP_CYCLES cycles:
  - ka_rst_n=1, ka_start=1, crypto_en=1.
  - Last cycle sets key_valid, then goes to LOAD; if num_blocks=0, done pulses and the next state is IDLE.
- ka_rst_n and crypto_en stay 1 from KEY until IDLE or abort.
- LOAD, BLOCK_BITS cycles: sipo_load=1. Then DWAIT.
- DWAIT, DEC_LATENCY cycles: no TDR enables. Then SHIFT.
- SHIFT, CHAIN_LEN cycles: shift_en=1. Then UPD.
- UPD, 1 cycle: update_en=1. Then CAP.
- CAP, 1 cycle:
  - capture_en=1 and blk_cnt increments.
  - If blk_cnt+1 < num_blocks_latched, go to LOAD; otherwise go to FLUSH.
- FLUSH, CHAIN_LEN cycles:
  - shift_en=1; shifts the final captured response out through the encryptor.
  - done=1 in the last cycle, then IDLE.
- Mutual exclusion: shift_en, update_en, capture_en and sipo_load are never high together (one-hot or all-zero).
- Phase counter:
  - Width is the clog2 of the largest phase length.
  - Reloads on every state entry; the state is left when the counter reaches length-1.
- Session length:
  - With rekey: KEY_EXP_CYCLES + N*(BLOCK_BITS+DEC_LATENCY+CHAIN_LEN+2) + CHAIN_LEN.
  - With defaults and N=1 this is 420 cycles.
- blk_cnt clears on go acceptance and holds its final value in IDLE.
- num_blocks=255 is legal; blk_cnt never wraps within a session.
- abort (in any non-IDLE state):
  - Next state is IDLE and all enables drop at the next edge.
  - ka_rst_n is driven to 0.
  - key_valid clears only if the abort hits KEY, otherwise it is kept; done is not pulsed.
  - abort together with go in IDLE: go wins, because abort has no effect in IDLE.
- Asynchronous reset mid-operation: all outputs return to their reset values immediately.

Optional Feature:
- Macro: SEQ_CYCLE_CNT_EN.
- When defined:
  - Adds output cyc_cnt [31:0], counting tck edges while busy=1.
  - It clears on go acceptance and holds its value in IDLE.
  - Reset value 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, state=0, key_valid=0.
- go=1, rekey=1, num_blocks=1 (defaults):
  - ka_start high for 11 cycles and sipo_load high for 128.
  - 23 idle cycles, then shift_en high for 128, update_en for 1, capture_en for 1, shift_en for 128.
  - done pulses exactly 420 cycles after go is accepted; blk_cnt=1.
- Second go with rekey=0, num_blocks=3 -> KEY skipped; LOAD entered the cycle after go; 3 update/capture pairs; blk_cnt ends at 3; done at cycle 3*281+128=971.
- go with num_blocks=0:
  - rekey=1 -> done in the 11th KEY cycle, no shift/update/capture activity.
  - rekey=0 with key_valid=1 -> done in the go cycle.
- abort asserted in SHIFT cycle 50 -> IDLE next cycle, shift_en=0, ka_rst_n=0, key_valid still 1, no done pulse; go held high during busy has no effect.
- With SEQ_CYCLE_CNT_EN, repeat the 1-block rekey session -> cyc_cnt=420 in IDLE afterwards. Without it, the same session produces identical output waveforms.
